// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths, NOP encoding and
// fetch state encodings.
package fetch_unit_pkg;

    localparam int DEFAULT_ADDR_W  = 10;
    localparam int DEFAULT_INSTR_W = 16;

    // NOP presented to the decoder whenever no on-path instruction is available
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // The fourth 2-bit code is unused and recovers to FLUSH_S
    typedef enum logic [1:0] {
        FETCH_S = 2'b00,
        STALL_S = 2'b01,
        FLUSH_S = 2'b10
    } fetchState_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register with full flag. Catches the ROM word that is in
// flight when the downstream stage stalls, so it can be replayed on release.
module fetch_skid #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] loadData,
    output logic [WIDTH-1:0] holdData,
    output logic             full
);

    // Clear beats load beats drain; a clear also drops the captured word
    always_ff @(posedge Clock) begin
        if (clear) begin
            full     <= 1'b0;
            holdData <= '0;
        end else if (load) begin
            full     <= 1'b1;
            holdData <= loadData;
        end else if (drain) begin
            full     <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM,
// squashes wrong-path words after a redirect and holds the stream on stall.
// Optional feature macro: FETCH_PERF_EN adds saturating instruction and
// redirect counters (rInstr_count, rRedirect_count).
//
// state   | meaning
// FLUSH_S | discarding ROM words after reset/redirect, PC advancing
// FETCH_S | presenting one ROM word per cycle
// STALL_S | output held, in-flight word parked in the skid register
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W       = DEFAULT_ADDR_W,
    parameter int                INSTR_W      = DEFAULT_INSTR_W,
    parameter int                FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               wBranch_taken,
    input  logic               wJumpTaken,
    input  logic [ADDR_W-1:0]  wBranch_dir,
    input  logic               wStall,
    input  logic [INSTR_W-1:0] wRom_data,
    output logic [ADDR_W-1:0]  rInstr_addr,
    output logic [INSTR_W-1:0] rInstruction,
    output logic               rValid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        rInstr_count,
    output logic [15:0]        rRedirect_count
`endif
);

    localparam logic [1:0]         FLUSH_INIT = 2'(FLUSH_CYCLES - 1);
    localparam logic [INSTR_W-1:0] NOP        = INSTR_W'(NOP_INSTR);

    fetchState_e        rState;
    logic [1:0]         rFlushCnt;
    logic               wRedirect;
    logic               wSkidClear;
    logic               wSkidLoad;
    logic               wSkidDrain;
    logic [INSTR_W-1:0] wSkidData;
    logic               wSkidFull;

    // Both redirect sources share the single decoder target
    assign wRedirect  = wBranch_taken | wJumpTaken;
    assign wSkidClear = Reset | wRedirect;
    assign wSkidLoad  = (rState == FETCH_S) && wStall;
    assign wSkidDrain = (rState == STALL_S) && !wStall;

    fetch_skid #(
        .WIDTH (INSTR_W)
    ) uSkid (
        .Clock    (Clock),
        .clear    (wSkidClear),
        .load     (wSkidLoad),
        .drain    (wSkidDrain),
        .loadData (wRom_data),
        .holdData (wSkidData),
        .full     (wSkidFull)
    );

    // Fetch FSM: reset > redirect > stall > advance, all outputs registered
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rInstr_addr  <= RESET_PC;
            rInstruction <= NOP;
            rValid       <= 1'b0;
            rState       <= FLUSH_S;
            rFlushCnt    <= FLUSH_INIT;
        end else if (wRedirect) begin
            rInstr_addr  <= wBranch_dir;
            rInstruction <= NOP;
            rValid       <= 1'b0;
            rState       <= FLUSH_S;
            rFlushCnt    <= FLUSH_INIT;
        end else begin
            case (rState)
                FLUSH_S: begin
                    rInstruction <= NOP;
                    rValid       <= 1'b0;
                    rInstr_addr  <= rInstr_addr + ADDR_W'(1);
                    if (rFlushCnt == 2'd0) begin
                        rState <= FETCH_S;
                    end else begin
                        rFlushCnt <= rFlushCnt - 2'd1;
                    end
                end
                FETCH_S: begin
                    if (wStall) begin
                        rState <= STALL_S;
                    end else begin
                        rInstruction <= wRom_data;
                        rValid       <= 1'b1;
                        rInstr_addr  <= rInstr_addr + ADDR_W'(1);
                    end
                end
                STALL_S: begin
                    // While stalled the ROM re-reads the held address, so that
                    // word reappears on wRom_data right after the release.
                    if (!wStall) begin
                        rInstruction <= wSkidFull ? wSkidData : wRom_data;
                        rValid       <= 1'b1;
                        rInstr_addr  <= rInstr_addr + ADDR_W'(1);
                        rState       <= FETCH_S;
                    end
                end
                default: begin
                    rInstruction <= NOP;
                    rValid       <= 1'b0;
                    rState       <= FLUSH_S;
                    rFlushCnt    <= FLUSH_INIT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic wLoadValid;

    assign wLoadValid = !wStall && ((rState == FETCH_S) || (rState == STALL_S));

    // Saturating counts of delivered instructions and redirects
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rInstr_count    <= 16'd0;
            rRedirect_count <= 16'd0;
        end else if (wRedirect) begin
            if (rRedirect_count != 16'hFFFF) begin
                rRedirect_count <= rRedirect_count + 16'd1;
            end
        end else if (wLoadValid && (rInstr_count != 16'hFFFF)) begin
            rInstr_count <= rInstr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized stall/redirect/
// reset traffic, checked every cycle against a word-stream reference model.
module tb_fetch_unit;

    localparam int FLUSH = 1;

    logic        Clock;
    logic        Reset;
    logic        wBranch_taken;
    logic        wJumpTaken;
    logic [9:0]  wBranch_dir;
    logic        wStall;
    logic [15:0] wRom_data;
    logic [9:0]  rInstr_addr;
    logic [15:0] rInstruction;
    logic        rValid;
`ifdef FETCH_PERF_EN
    logic [15:0] rInstr_count;
    logic [15:0] rRedirect_count;
`endif

    int checkCount = 0;
    int errCount   = 0;

    // reference model state
    logic [9:0]  mPc;
    logic [9:0]  mPcOld;
    logic [15:0] mInstr;
    logic        mValid;
    int          mDiscard;
    logic [15:0] mHeld[$];
    int          mInstrCnt;
    int          mRedirCnt;

    fetch_unit #(
        .ADDR_W       (10),
        .INSTR_W      (16),
        .FLUSH_CYCLES (FLUSH),
        .RESET_PC     (10'h000)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .wBranch_taken (wBranch_taken),
        .wJumpTaken    (wJumpTaken),
        .wBranch_dir   (wBranch_dir),
        .wStall        (wStall),
        .wRom_data     (wRom_data),
        .rInstr_addr   (rInstr_addr),
        .rInstruction  (rInstruction),
        .rValid        (rValid)
`ifdef FETCH_PERF_EN
        ,
        .rInstr_count    (rInstr_count),
        .rRedirect_count (rRedirect_count)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [15:0] romWord(logic [9:0] a);
        return 16'h1000 + {6'd0, a};
    endfunction

    // synchronous ROM: data is the word at last cycle's address
    always @(posedge Clock) wRom_data <= romWord(rInstr_addr);

    task automatic checkValue(string tag, logic [31:0] got, logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the stage delivers consecutive ROM words; after reset/redirect it
    // throws away FLUSH words; a stall parks one word and replays it later.
    task automatic modelStep();
        logic [15:0] romIn;
        romIn  = romWord(mPcOld);
        mPcOld = mPc;
        if (Reset) begin
            mPc = 10'h000; mInstr = 16'h0000; mValid = 1'b0;
            mDiscard = FLUSH; mHeld.delete();
            mInstrCnt = 0; mRedirCnt = 0;
        end else if (wBranch_taken || wJumpTaken) begin
            mPc = wBranch_dir; mInstr = 16'h0000; mValid = 1'b0;
            mDiscard = FLUSH; mHeld.delete();
            if (mRedirCnt < 65535) mRedirCnt++;
        end else if (mDiscard > 0) begin
            mDiscard--; mPc = mPc + 10'd1; mInstr = 16'h0000; mValid = 1'b0;
        end else if (wStall) begin
            if (mHeld.size() == 0) mHeld.push_back(romIn);
        end else begin
            mInstr = (mHeld.size() != 0) ? mHeld.pop_front() : romIn;
            mValid = 1'b1;
            mPc    = mPc + 10'd1;
            if (mInstrCnt < 65535) mInstrCnt++;
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        modelStep();
        #1;
        checkValue("addr", 32'(rInstr_addr), 32'(mPc));
        checkValue("instr", 32'(rInstruction), 32'(mInstr));
        checkValue("valid", 32'(rValid), 32'(mValid));
`ifdef FETCH_PERF_EN
        checkValue("instr_count", 32'(rInstr_count), 32'(mInstrCnt));
        checkValue("redirect_count", 32'(rRedirect_count), 32'(mRedirCnt));
`endif
    endtask

    initial begin
        Reset = 1'b1; wBranch_taken = 1'b0; wJumpTaken = 1'b0;
        wBranch_dir = 10'h000; wStall = 1'b0;
        mPc = 10'h000; mPcOld = 10'h000; mInstr = 16'h0000; mValid = 1'b0;
        mDiscard = FLUSH; mInstrCnt = 0; mRedirCnt = 0;

        // reset state and release
        repeat (3) tick();
        checkValue("rst_addr", 32'(rInstr_addr), 32'h000);
        checkValue("rst_instr", 32'(rInstruction), 32'h0000);
        checkValue("rst_valid", 32'(rValid), 32'h0);
        Reset = 1'b0;
        tick();
        checkValue("e1_valid", 32'(rValid), 32'h0);
        tick();
        checkValue("e2_instr", 32'(rInstruction), 32'h1000);
        checkValue("e2_valid", 32'(rValid), 32'h1);
        tick();
        checkValue("e3_instr", 32'(rInstruction), 32'h1001);
        tick();
        checkValue("e4_instr", 32'(rInstruction), 32'h1002);
        tick();
        checkValue("pre_jump_addr", 32'(rInstr_addr), 32'h005);

        // jump to 0x150
        wJumpTaken = 1'b1; wBranch_dir = 10'h150;
        tick();
        wJumpTaken = 1'b0;
        checkValue("jump_addr", 32'(rInstr_addr), 32'h150);
        checkValue("jump_valid", 32'(rValid), 32'h0);
        checkValue("jump_nop", 32'(rInstruction), 32'h0000);
        tick();
        tick();
        checkValue("jump_first", 32'(rInstruction), 32'h1150);
        checkValue("jump_first_valid", 32'(rValid), 32'h1);

        // 3-cycle stall at 0x1004
        Reset = 1'b1; tick(); Reset = 1'b0;
        repeat (6) tick();
        checkValue("pre_stall", 32'(rInstruction), 32'h1004);
        wStall = 1'b1;
        repeat (3) begin
            tick();
            checkValue("stall_hold", 32'(rInstruction), 32'h1004);
        end
        wStall = 1'b0;
        tick();
        checkValue("stall_rel1", 32'(rInstruction), 32'h1005);
        tick();
        checkValue("stall_rel2", 32'(rInstruction), 32'h1006);

        // redirect while stalled; stall stays high through the flush
        wStall = 1'b1;
        tick();
        wBranch_taken = 1'b1; wBranch_dir = 10'h020;
        tick();
        wBranch_taken = 1'b0;
        checkValue("stall_redir_addr", 32'(rInstr_addr), 32'h020);
        checkValue("stall_redir_valid", 32'(rValid), 32'h0);
        tick();
        checkValue("flush_ign_stall", 32'(rInstr_addr), 32'h021);
        wStall = 1'b0;
        tick();
        checkValue("stall_redir_first", 32'(rInstruction), 32'h1020);
        checkValue("stall_redir_fvalid", 32'(rValid), 32'h1);

        // PC wrap
        wJumpTaken = 1'b1; wBranch_dir = 10'h3FE;
        tick();
        wJumpTaken = 1'b0;
        checkValue("wrap_a0", 32'(rInstr_addr), 32'h3FE);
        tick();
        checkValue("wrap_a1", 32'(rInstr_addr), 32'h3FF);
        tick();
        checkValue("wrap_a2", 32'(rInstr_addr), 32'h000);
        checkValue("wrap_i0", 32'(rInstruction), 32'h13FE);
        tick();
        checkValue("wrap_i1", 32'(rInstruction), 32'h13FF);
        tick();
        checkValue("wrap_i2", 32'(rInstruction), 32'h1000);

        // reset mid-stall with both redirect sources high
        wStall = 1'b1;
        tick(); tick();
        Reset = 1'b1; wJumpTaken = 1'b1; wBranch_taken = 1'b1; wBranch_dir = 10'h0AA;
        tick();
        checkValue("rst_stall_addr", 32'(rInstr_addr), 32'h000);
        checkValue("rst_stall_instr", 32'(rInstruction), 32'h0000);
        checkValue("rst_stall_valid", 32'(rValid), 32'h0);
        Reset = 1'b0;
        tick();
        checkValue("dual_addr", 32'(rInstr_addr), 32'h0AA);
`ifdef FETCH_PERF_EN
        checkValue("dual_redir_cnt", 32'(rRedirect_count), 32'd1);
`endif
        wJumpTaken = 1'b0; wBranch_taken = 1'b0; wStall = 1'b0;
        tick(); tick();
        checkValue("dual_first", 32'(rInstruction), 32'h10AA);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Reset         = ($urandom_range(0, 199) == 0);
            wBranch_taken = ($urandom_range(0, 99) < 4);
            wJumpTaken    = ($urandom_range(0, 99) < 3);
            wBranch_dir   = 10'($urandom);
            wStall        = ($urandom_range(0, 99) < 35);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage for the 8-bit accumulator CPU. It owns the 10-bit program counter and drives the synchronous instruction ROM.
- Presents one registered 16-bit instruction per cycle to the instruction decoder.
- Consumes the decoder's branch-taken, jump-taken and 10-bit target outputs to redirect the PC. Squashes wrong-path instructions with NOPs.
- Holds the instruction stream on a back-pressure stall through a one-entry skid register.

Parameters:
- ADDR_W, 10, PC / ROM address width.
- INSTR_W, 16, instruction width.
- FLUSH_CYCLES, 1, cycles of ROM data discarded after a redirect or reset; range 1..3.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- wBranch_taken  in  1  conditional branch taken, from decoder.
- wJumpTaken  in  1  unconditional jump, from decoder.
- wBranch_dir  in  ADDR_W  absolute redirect target, from decoder.
- wStall  in  1  downstream cannot accept a new instruction this cycle.
- wRom_data  in  INSTR_W  ROM read data; equals mem[rInstr_addr of previous cycle].
- rInstr_addr  out  ADDR_W  ROM read address (the PC).
- rInstruction  out  INSTR_W  instruction to decoder; NOP (16'h0000) when not valid.
- rValid  out  1  rInstruction is a real, on-path instruction.

Behaviour:
- All outputs are registered; every input is sampled on the rising edge of Clock.
- Reset priority: Reset > redirect > stall > normal advance.
- Reset values:
  - rInstr_addr = RESET_PC; rInstruction = NOP; rValid = 0.
  - Skid register empty; state = FLUSH; flush counter = FLUSH_CYCLES-1.
  - Reset mid-stall or mid-flush discards all in-flight data.
- Redirect = wBranch_taken | wJumpTaken. If both are high, the target is still wBranch_dir.
- On a redirect edge, from any state:
  - rInstr_addr <= wBranch_dir; rInstruction <= NOP; rValid <= 0; skid cleared.
  - state <= FLUSH; counter <= FLUSH_CYCLES-1.
- FLUSH:
  - wRom_data is discarded; rInstruction = NOP; rValid = 0.
  - rInstr_addr increments every cycle; wStall is ignored.
  - When counter = 0, state goes to FETCH; otherwise counter decrements.
  - With FLUSH_CYCLES = 1, the first valid instruction is mem[target], two edges after the redirect edge.
- FETCH with wStall = 0: rInstruction <= wRom_data; rValid <= 1; rInstr_addr <= rInstr_addr+1.
- FETCH with wStall = 1:
  - skid <= wRom_data; skid_full <= 1.
  - rInstr_addr, rInstruction and rValid are held; state goes to STALL.
- STALL:
  - wStall = 1: everything is held, and wRom_data (mem[held addr]) is ignored.
  - wStall = 0: rInstruction <= skid; rValid <= 1; skid_full <= 0; rInstr_addr <= +1; state goes to FETCH.
  - The next cycle's wRom_data is then mem[held addr], so no instruction is lost or duplicated.
- PC wraps from 10'h3FF to 10'h000 with no flag.
- States are encoded in 2 bits; the unused code goes to FLUSH with counter = FLUSH_CYCLES-1.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, two extra outputs are added:
  - rInstr_count [15:0]: increments on each edge where rValid is loaded with 1.
  - rRedirect_count [15:0]: increments on each redirect edge.
  - Both counters saturate at 16'hFFFF and clear on Reset.
- When undefined, neither port nor logic exists, and the remaining behaviour is identical cycle-for-cycle.

Decomposition:
- Shared definitions file:
  - NOP encoding 16'h0000.
  - ADDR_W / INSTR_W defaults.
  - fetch state encodings FETCH_S, STALL_S, FLUSH_S.
- One natural sub-module, fetch_skid: a one-entry holding register with full flag, plus load, drain and clear controls. Everything else stays inline.

Test Plan:
- Reset release with ROM mem[n] = 16'h1000+n, no stall:
  - rInstr_addr is 0,1,2,… from the first edge.
  - rValid first rises at edge 2 with rInstruction = 16'h1000, then 16'h1001, 16'h1002 on consecutive cycles.
- Jump with wJumpTaken = 1, wBranch_dir = 10'h150 while fetching at addr 5:
  - Next edge: addr = 10'h150, rValid = 0, rInstruction = NOP.
  - Two edges after the jump: rInstruction = 16'h1150, rValid = 1.
- Stall for 3 cycles starting when rInstruction = 16'h1004:
  - rInstruction stays 16'h1004 for all 3 cycles.
  - Then 16'h1005, 16'h1006 follow, with no gap or duplicate.
- Redirect during STALL (wStall = 1, wBranch_taken = 1, target 10'h020):
  - Skid is cleared; addr = 10'h020; FLUSH is entered.
  - The first valid instruction is 16'h1020.
- PC wrap: free-run from addr 10'h3FE. Addresses go 3FE, 3FF, 000, and instructions follow 16'h13FE, 16'h13FF, 16'h1000.
- Reset asserted mid-STALL, and wJumpTaken = wBranch_taken = 1 simultaneously:
  - Outputs return to reset values.
  - The later dual redirect goes to wBranch_dir.
  - With FETCH_PERF_EN defined, rRedirect_count increments by exactly 1.
